// File: rtl/mandel_pkg.sv
// Shared types and helpers for the mandelbrot counter streamer.
package mandel_pkg;

    // Streamer FSM: wait for data, move FIFO head to the output register, present nibbles.
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShow
    } stream_state_e;

    // Edge-detector blind cycles after reset release.
    localparam int unsigned ArmCycles = 3;

    // Number of 4-bit nibbles needed to carry a w-bit count.
    function automatic int unsigned nibbles(input int unsigned w);
        return (w + 3) / 4;
    endfunction

endpackage

// File: rtl/mandel_sync_fifo.sv
// Small synchronous FIFO with registered storage; read-first on simultaneous push and pop.
module mandel_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // Head is read straight from storage, so a same-cycle push never bypasses into dout.
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and storage; a pop frees a slot for a push at full.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mandel_ctr_streamer.sv
// Buffers finished iteration counts and streams them to a slow host one nibble per toggle.
module mandel_ctr_streamer
    import mandel_pkg::*;
#(
    parameter int unsigned CTRWIDTH = 7,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CTRWIDTH-1:0]            ctr_in,
    input  logic                           ctr_valid,
    input  logic                           frame_start,
    input  logic                           host_step,
    output logic [3:0]                     out_nibble,
    output logic                           out_valid,
    output logic                           out_first,
    output logic                           overflow,
    output logic [$clog2(DEPTH+1)-1:0]     fill
);

    localparam int unsigned NIBBLES = nibbles(CTRWIDTH);
    localparam int unsigned PIXW    = NIBBLES * 4;
    localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned ENTW    = CTRWIDTH + 1;

    stream_state_e      state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [PIXW-1:0]    pix_q, pix_d;
    logic               first_q, first_d;
    logic               overflow_q, overflow_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               prev_q, prev_d;
    logic               step_q, step_d;
    logic [1:0]         arm_cnt_q, arm_cnt_d;
    logic               armed;

    logic               fifo_pop;
    logic [ENTW-1:0]    fifo_din;
    logic [ENTW-1:0]    fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [3:0]         nib_sel;

    assign fifo_din = {frame_start, ctr_in};

    mandel_sync_fifo #(
        .WIDTH (ENTW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ctr_valid),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill)
    );

    // Synchronizer, arming counter and registered toggle detector for the host pin.
    always_comb begin
        armed     = (arm_cnt_q == 2'(ArmCycles));
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
        sync1_d   = host_step;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        // prev keeps tracking while disarmed so toggles in the blind window are lost, not deferred.
        step_d    = armed & (sync2_q != prev_q);
    end

    // Sticky drop flag: pixel arrives at a full FIFO that is not popping this cycle.
    always_comb begin
        overflow_d = overflow_q | (ctr_valid & fifo_full & ~fifo_pop);
    end

    // Streamer FSM next-state; steps outside SHOW are discarded.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pix_d    = pix_q;
        first_d  = first_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                fifo_pop = 1'b1;
                pix_d    = PIXW'(fifo_dout[CTRWIDTH-1:0]);
                first_d  = fifo_dout[CTRWIDTH];
                idx_d    = '0;
                state_d  = StShow;
            end
            StShow: begin
                if (step_q) begin
                    if (idx_q == IDXW'(NIBBLES - 1)) begin
                        state_d = fifo_empty ? StIdle : StLoad;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // All state registers, synchronously reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            pix_q      <= '0;
            first_q    <= 1'b0;
            overflow_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            step_q     <= 1'b0;
            arm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pix_q      <= pix_d;
            first_q    <= first_d;
            overflow_q <= overflow_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            step_q     <= step_d;
            arm_cnt_q  <= arm_cnt_d;
        end
    end

    // Output nibble mux; outputs are forced to zero outside SHOW.
    always_comb begin
        nib_sel = 4'd0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx_q == IDXW'(k)) begin
                nib_sel = pix_q[4*k +: 4];
            end
        end
        out_valid  = (state_q == StShow);
        out_nibble = out_valid ? nib_sel : 4'd0;
        out_first  = out_valid & first_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_mandel_ctr_streamer.sv
// Scoreboard bench for mandel_ctr_streamer: directed scenarios plus a randomized phase.
module tb_mandel_ctr_streamer;

    localparam int CW    = 7;
    localparam int DEPTH = 4;
    localparam int NIB   = (CW + 3) / 4;
    localparam int FW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] ctr_in = '0;
    logic          ctr_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic          host_step = 1'b0;
    logic [3:0]    out_nibble;
    logic          out_valid;
    logic          out_first;
    logic          overflow;
    logic [FW-1:0] fill;

    mandel_ctr_streamer #(
        .CTRWIDTH (CW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ctr_in      (ctr_in),
        .ctr_valid   (ctr_valid),
        .frame_start (frame_start),
        .host_step   (host_step),
        .out_nibble  (out_nibble),
        .out_valid   (out_valid),
        .out_first   (out_first),
        .overflow    (overflow),
        .fill        (fill)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];          // expected pixels in stream order: ctr | first<<16
    int accepted = 0;      // pixels the model says entered the FIFO
    int popped = 0;        // pixels the monitor has seen appear

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nib_of(input int pix, input int k);
        return (pix >> (4 * k)) & 15;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_px(input int ctr, input bit first, input bit accept);
        ctr_in      = CW'(ctr);
        ctr_valid   = 1'b1;
        frame_start = first;
        if (accept) begin
            exp_q.push_back(ctr | (int'(first) << 16));
            accepted++;
        end
        tick(1);
        ctr_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic toggle();
        host_step = ~host_step;
        tick(6);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        accepted = 0;
        popped   = 0;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_nibble"}, int'(out_nibble), 0);
        chk({tag, "_first"}, int'(out_first), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_fill"}, int'(fill), 0);
    endtask

    // Monitor: acts like the host reader, checking each nibble as it is presented.
    initial begin : monitor
        int  cyc = 0;
        int  due = 0;
        int  nib = 0;
        int  cur = 0;
        bit  active = 1'b0;
        bit  prev_ov = 1'b0;
        logic last_hs = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!out_valid) begin
                active = 1'b0;
                due    = 0;
            end else if (!prev_ov) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got nibble 0x%0h, expected none", out_nibble);
                end else begin
                    cur = exp_q.pop_front();
                    popped++;
                    nib = 0;
                    chk("mon_nibble0", int'(out_nibble), nib_of(cur, 0));
                    chk("mon_first0", int'(out_first), (cur >> 16) & 1);
                end
                active = 1'b1;
            end
            if (due != 0 && cyc == due) begin
                due = 0;
                nib++;
                chk("mon_valid_step", int'(out_valid), 1);
                chk("mon_nibble_step", int'(out_nibble), nib_of(cur, nib));
                chk("mon_first_step", int'(out_first), (cur >> 16) & 1);
            end
            if (host_step !== last_hs) begin
                last_hs = host_step;
                if (active && nib < NIB - 1) due = cyc + 4;
            end
            prev_ov = out_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        tick(2);
        chk_idle_zero("in_reset");
        reset = 1'b0;
        tick(4);
        chk_idle_zero("after_reset");

        // Single pixel 0x5A.
        push_px(8'h5A, 1'b0, 1'b1);
        chk("single_fill", int'(fill), 1);
        tick(2);
        chk("single_valid", int'(out_valid), 1);
        chk("single_nib0", int'(out_nibble), 4'hA);
        toggle();
        chk("single_nib1", int'(out_nibble), 4'h5);
        toggle();
        chk("single_done_valid", int'(out_valid), 0);
        chk("single_done_fill", int'(fill), 0);

        // Frame marker.
        push_px(8'h01, 1'b1, 1'b1);
        push_px(8'h02, 1'b0, 1'b1);
        tick(1);
        chk("frame_p1n0", int'(out_nibble), 1);
        chk("frame_p1n0_first", int'(out_first), 1);
        toggle();
        chk("frame_p1n1", int'(out_nibble), 0);
        chk("frame_p1n1_first", int'(out_first), 1);
        toggle();
        chk("frame_p2n0", int'(out_nibble), 2);
        chk("frame_p2n0_first", int'(out_first), 0);
        toggle();
        chk("frame_p2n1", int'(out_nibble), 0);
        chk("frame_p2n1_first", int'(out_first), 0);
        toggle();

        // Overflow: one pixel goes to the display, DEPTH are held, the rest drop.
        for (int i = 0; i < 6; i++) push_px(8'h10 + i, 1'b0, i < DEPTH + 1);
        chk("ovf_fill", int'(fill), DEPTH);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_valid", int'(out_valid), 1);
        chk("ovf_nib0", int'(out_nibble), 0);
        for (int i = 0; i < 2 * (DEPTH + 1); i++) toggle();
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_sticky", int'(overflow), 1);
        chk("ovf_idle", int'(out_valid), 0);
        do_reset();
        chk("ovf_cleared", int'(overflow), 0);
        tick(4);

        // Push at full coinciding with a pop.
        for (int i = 0; i < 5; i++) push_px(8'h20 + i, 1'b0, 1'b1);
        chk("fullpop_fill_pre", int'(fill), DEPTH);
        toggle();
        host_step = ~host_step;
        tick(4);
        ctr_in    = 7'h33;
        ctr_valid = 1'b1;
        exp_q.push_back(32'h33);
        accepted++;
        tick(1);
        ctr_valid = 1'b0;
        chk("fullpop_overflow", int'(overflow), 0);
        chk("fullpop_fill", int'(fill), DEPTH);
        tick(2);
        for (int i = 0; i < 10; i++) toggle();
        chk("fullpop_drained", exp_q.size(), 0);
        chk("fullpop_fill_end", int'(fill), 0);

        // Reset mid-operation, then a toggle inside the blind window.
        for (int i = 0; i < 3; i++) push_px(8'h41 + i, 1'b0, 1'b1);
        toggle();
        chk("rst_pre_nib1", int'(out_nibble), 4);
        do_reset();
        chk_idle_zero("rst_mid");
        host_step = ~host_step;
        push_px(8'h6C, 1'b0, 1'b1);
        tick(6);
        chk("rst_noadv_valid", int'(out_valid), 1);
        chk("rst_noadv_nib", int'(out_nibble), 4'hC);
        toggle();
        chk("rst_nib1", int'(out_nibble), 6);
        toggle();
        chk("rst_done", int'(out_valid), 0);

        // Stray toggles while idle.
        for (int i = 0; i < 5; i++) toggle();
        push_px(8'h7F, 1'b0, 1'b1);
        tick(2);
        chk("stray_nib0", int'(out_nibble), 4'hF);
        tick(10);
        chk("stray_hold", int'(out_nibble), 4'hF);
        toggle();
        chk("stray_nib1", int'(out_nibble), 7);
        toggle();
        chk("stray_done", int'(out_valid), 0);

        // Randomized traffic kept within FIFO capacity.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4 && accepted - popped < DEPTH) begin
                push_px($urandom_range(0, 127), 1'($urandom_range(0, 1)), 1'b1);
            end else if (r < 8 && out_valid) begin
                toggle();
            end else begin
                tick($urandom_range(1, 3));
            end
        end
        for (int g = 0; g < 200 && (exp_q.size() > 0 || out_valid); g++) begin
            if (out_valid) toggle();
            else tick(1);
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_valid", int'(out_valid), 0);
        chk("rand_overflow", int'(overflow), 0);
        chk("rand_fill", int'(fill), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
